// File: rtl/jtag_ir_decoder_param.sv
// rtl/jtag_ir_decoder_param.sv - JTAG instruction register, decoder, clamp-hold FSM and TDO mux
module jtag_ir_decoder_param #(
  parameter int                  IR_WIDTH         = 4,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST        = 'h0,
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE        = 'h1,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE        = 'h2,
  parameter logic [IR_WIDTH-1:0] OP_CLAMP         = 'h3,
  parameter logic [IR_WIDTH-1:0] OP_CLAMP_HOLD    = 'h4,
  parameter logic [IR_WIDTH-1:0] OP_CLAMP_RELEASE = 'h5,
  parameter logic [IR_WIDTH-1:0] OP_TMP_STATUS    = 'h6,
  parameter logic [IR_WIDTH-1:0] OP_AHB           = 'h7
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                tlr_reset,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  input  logic                shift_dr,
  input  logic                tdi,
  input  logic                bsr_tdo,
  input  logic                id_tdo,
  input  logic                bypass_tdo,
  input  logic                tmp_tdo,
  input  logic                ahb_tdo,
  output logic                tdo_int,
  output logic [IR_WIDTH-1:0] instr,
  output logic                bsr_select,
  output logic                id_select,
  output logic                bypass_select,
  output logic                tmp_select,
  output logic                ahb_select,
  output logic                bsr_mode,
  output logic                clamp_hold_decode,
  output logic                clamp_release_decode,
  output logic                bypass_decode,
  output logic                clamp_held,
  output logic                unknown_instr
);

  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;

  typedef enum logic {RELEASED = 1'b0, HELD = 1'b1} clamp_state_t;

  clamp_state_t        clamp_state;
  clamp_state_t        clamp_next;
  logic [IR_WIDTH-1:0] shift_q;
  logic [IR_WIDTH-1:0] capture_val;
  logic                dr_tdo;

  // Cast truncates the clamp bit away for 3-bit IRs and zero-fills wider ones.
  assign capture_val = IR_WIDTH'({clamp_held, unknown_instr, 2'b01});

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      shift_q <= '0;
      instr   <= OP_IDCODE;
    end else if (tlr_reset) begin
      instr   <= OP_IDCODE;
    end else if (update_ir) begin
      instr   <= shift_q;
    end else if (capture_ir) begin
      shift_q <= capture_val;
    end else if (shift_ir) begin
      shift_q <= {tdi, shift_q[IR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) clamp_state <= RELEASED;
    else       clamp_state <= clamp_next;
  end

  // Test-Logic-Reset outranks update_ir, so a simultaneous update cannot move the clamp.
  always_comb begin
    clamp_next = clamp_state;
    if (!tlr_reset && update_ir) begin
      case (clamp_state)
        RELEASED: if (shift_q == OP_CLAMP_HOLD)    clamp_next = HELD;
        HELD:     if (shift_q == OP_CLAMP_RELEASE) clamp_next = RELEASED;
        default:  clamp_next = RELEASED;
      endcase
    end
  end

  always_comb begin
    clamp_held = (clamp_state == HELD);
  end

  always_comb begin
    bsr_select           = 1'b0;
    id_select            = 1'b0;
    bypass_select        = 1'b0;
    tmp_select           = 1'b0;
    ahb_select           = 1'b0;
    clamp_hold_decode    = 1'b0;
    clamp_release_decode = 1'b0;
    bypass_decode        = 1'b0;
    unknown_instr        = 1'b0;
    case (instr)
      OP_EXTEST, OP_SAMPLE, OP_CLAMP: bsr_select = 1'b1;
      OP_IDCODE:     id_select  = 1'b1;
      OP_TMP_STATUS: tmp_select = 1'b1;
      OP_AHB:        ahb_select = 1'b1;
      OP_CLAMP_HOLD: begin
        bypass_select     = 1'b1;
        clamp_hold_decode = 1'b1;
      end
      OP_CLAMP_RELEASE: begin
        bypass_select        = 1'b1;
        clamp_release_decode = 1'b1;
      end
      OP_BYPASS: begin
        bypass_select = 1'b1;
        bypass_decode = 1'b1;
      end
      default: begin
        bypass_select = 1'b1;
        unknown_instr = 1'b1;
      end
    endcase
  end

  assign bsr_mode = (instr == OP_EXTEST) | (instr == OP_CLAMP) | clamp_held;

  // Selects are one-hot, so an AND-OR mux suffices.
  assign dr_tdo = (bsr_select & bsr_tdo) | (id_select & id_tdo) |
                  (bypass_select & bypass_tdo) | (tmp_select & tmp_tdo) |
                  (ahb_select & ahb_tdo);

  assign tdo_int = shift_ir ? shift_q[0] : (shift_dr ? dr_tdo : 1'b0);

endmodule

// File: tb/tb_jtag_ir_decoder_param.sv
// tb/tb_jtag_ir_decoder_param.sv - directed and randomized checks of 4-bit and 8-bit IR decoders
module tb_jtag_ir_decoder_param;

  logic TCK = 1'b0;
  logic TRST = 1'b0;
  logic tlr_reset = 1'b0, capture_ir = 1'b0, shift_ir = 1'b0, update_ir = 1'b0, shift_dr = 1'b0;
  logic tdi4 = 1'b0, tdi8 = 1'b0;
  logic bsr_tdo = 1'b0, id_tdo = 1'b0, bypass_tdo = 1'b0, tmp_tdo = 1'b0, ahb_tdo = 1'b0;
  logic [1:0] tdo_int, bsr_select, id_select, bypass_select, tmp_select, ahb_select;
  logic [1:0] bsr_mode, hold_dec, rel_dec, byp_dec, clamp_held, unknown_instr;
  logic [3:0] instr4;
  logic [7:0] instr8;
  int tests = 0;
  int fails = 0;

  always #5 TCK = ~TCK;

  jtag_ir_decoder_param u4 (
    .TCK(TCK), .TRST(TRST), .tlr_reset(tlr_reset), .capture_ir(capture_ir),
    .shift_ir(shift_ir), .update_ir(update_ir), .shift_dr(shift_dr), .tdi(tdi4),
    .bsr_tdo(bsr_tdo), .id_tdo(id_tdo), .bypass_tdo(bypass_tdo), .tmp_tdo(tmp_tdo),
    .ahb_tdo(ahb_tdo), .tdo_int(tdo_int[0]), .instr(instr4),
    .bsr_select(bsr_select[0]), .id_select(id_select[0]), .bypass_select(bypass_select[0]),
    .tmp_select(tmp_select[0]), .ahb_select(ahb_select[0]), .bsr_mode(bsr_mode[0]),
    .clamp_hold_decode(hold_dec[0]), .clamp_release_decode(rel_dec[0]),
    .bypass_decode(byp_dec[0]), .clamp_held(clamp_held[0]), .unknown_instr(unknown_instr[0])
  );

  jtag_ir_decoder_param #(
    .IR_WIDTH(8), .OP_EXTEST(8'h10), .OP_SAMPLE(8'h21), .OP_IDCODE(8'h32), .OP_CLAMP(8'h43),
    .OP_CLAMP_HOLD(8'h54), .OP_CLAMP_RELEASE(8'h65), .OP_TMP_STATUS(8'h76), .OP_AHB(8'h87)
  ) u8 (
    .TCK(TCK), .TRST(TRST), .tlr_reset(tlr_reset), .capture_ir(capture_ir),
    .shift_ir(shift_ir), .update_ir(update_ir), .shift_dr(shift_dr), .tdi(tdi8),
    .bsr_tdo(bsr_tdo), .id_tdo(id_tdo), .bypass_tdo(bypass_tdo), .tmp_tdo(tmp_tdo),
    .ahb_tdo(ahb_tdo), .tdo_int(tdo_int[1]), .instr(instr8),
    .bsr_select(bsr_select[1]), .id_select(id_select[1]), .bypass_select(bypass_select[1]),
    .tmp_select(tmp_select[1]), .ahb_select(ahb_select[1]), .bsr_mode(bsr_mode[1]),
    .clamp_hold_decode(hold_dec[1]), .clamp_release_decode(rel_dec[1]),
    .bypass_decode(byp_dec[1]), .clamp_held(clamp_held[1]), .unknown_instr(unknown_instr[1])
  );

  // Reference model: opcode table index 0..7 = EXTEST,SAMPLE,IDCODE,CLAMP,HOLD,RELEASE,TMP,AHB
  int w[2] = '{4, 8};
  int op[2][8] = '{'{'h0, 'h1, 'h2, 'h3, 'h4, 'h5, 'h6, 'h7},
                   '{'h10, 'h21, 'h32, 'h43, 'h54, 'h65, 'h76, 'h87}};
  int m_sr[2];
  int m_instr[2];
  bit m_held[2];
  bit pre_act[2];
  bit pre_exp[2];

  function automatic int cls(int d, int v);
    for (int k = 0; k < 8; k++) if (v == op[d][k]) return k;
    if (v == (1 << w[d]) - 1) return 8;
    return 9;
  endfunction

  function automatic logic [10:0] exp_vec(int d);
    int c;
    c = cls(d, m_instr[d]);
    return {(c == 0 || c == 1 || c == 3), (c == 2), (c == 4 || c == 5 || c == 8 || c == 9),
            (c == 6), (c == 7), (c == 0 || c == 3 || m_held[d]), (c == 4), (c == 5),
            (c == 8), m_held[d], (c == 9)};
  endfunction

  function automatic logic [10:0] act_vec(int d);
    return {bsr_select[d], id_select[d], bypass_select[d], tmp_select[d], ahb_select[d],
            bsr_mode[d], hold_dec[d], rel_dec[d], byp_dec[d], clamp_held[d], unknown_instr[d]};
  endfunction

  function automatic int act_instr(int d);
    return (d != 0) ? int'(instr8) : int'(instr4);
  endfunction

  function automatic bit exp_tdo(int d);
    int c;
    c = cls(d, m_instr[d]);
    if (shift_ir) return (m_sr[d] & 1) != 0;
    if (!shift_dr) return 1'b0;
    case (c)
      0, 1, 3: return bsr_tdo;
      2:       return id_tdo;
      6:       return tmp_tdo;
      7:       return ahb_tdo;
      default: return bypass_tdo;
    endcase
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sr[d] = 0;
      m_instr[d] = op[d][2];
      m_held[d] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int d = 0; d < 2; d++) begin
      bit t;
      t = (d == 0) ? tdi4 : tdi8;
      if (tlr_reset) m_instr[d] = op[d][2];
      else if (update_ir) begin
        m_instr[d] = m_sr[d];
        if (m_sr[d] == op[d][4]) m_held[d] = 1'b1;
        else if (m_sr[d] == op[d][5]) m_held[d] = 1'b0;
      end else if (capture_ir)
        m_sr[d] = 1 | ((cls(d, m_instr[d]) == 9) ? 4 : 0) | ((w[d] >= 4 && m_held[d]) ? 8 : 0);
      else if (shift_ir)
        m_sr[d] = (m_sr[d] >> 1) | (t ? (1 << (w[d] - 1)) : 0);
    end
  endfunction

  task automatic cycle(input int tlr, input int cap, input int sh, input int upd,
                       input int sdr, input int t4, input int t8);
    tlr_reset = (tlr != 0); capture_ir = (cap != 0); shift_ir = (sh != 0);
    update_ir = (upd != 0); shift_dr = (sdr != 0); tdi4 = (t4 != 0); tdi8 = (t8 != 0);
    #1;
    for (int d = 0; d < 2; d++) begin
      pre_act[d] = tdo_int[d];
      pre_exp[d] = exp_tdo(d);
    end
    @(posedge TCK);
    model_edge();
    #1;
  endtask

  // Eight shifts: the 4-bit IR keeps only the last four, so v4 rides in the upper nibble.
  task automatic load(input int v4, input int v8);
    cycle(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      cycle(0, 0, 1, 0, 0, (i >= 4) ? ((v4 >> (i - 4)) & 1) : 0, (v8 >> i) & 1);
    cycle(0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_reset();
    TRST = 1'b0;
    model_reset();
    repeat (2) @(posedge TCK);
    #1 TRST = 1'b1;
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 1, 1);
    cycle(0, 0, 1, 0, 0, 1, 1);
    cycle(0, 0, 1, 0, 0, 0, 0);
    #2 TRST = 1'b0;
    model_reset();
    #1;
    tests++; if (instr4 !== 4'h2) begin fails++; $display("FAIL async_reset_instr4: got %h want 2", instr4); end
    tests++; if (instr8 !== 8'h32) begin fails++; $display("FAIL async_reset_instr8: got %h want 32", instr8); end
    #1 TRST = 1'b1;
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
    tests++; if (instr4 !== 4'h2 || id_select !== 2'b11) begin fails++; $display("FAIL reset_idcode: instr4=%h id_select=%b want 2/11", instr4, id_select); end
    tests++; if (clamp_held !== 2'b00 || tdo_int !== 2'b00) begin fails++; $display("FAIL reset_idle: clamp_held=%b tdo_int=%b want 00/00", clamp_held, tdo_int); end
    for (int d = 0; d < 2; d++) begin
      tests++; if (act_vec(d) !== exp_vec(d)) begin fails++; $display("FAIL reset_decode dut%0d: got %b want %b", d, act_vec(d), exp_vec(d)); end
    end
    // Partial shift was discarded: updating now loads an all-zero register.
    cycle(0, 0, 0, 1, 0, 0, 0);
    tests++; if (instr4 !== 4'h0 || instr8 !== 8'h00) begin fails++; $display("FAIL reset_discard: instr4=%h instr8=%h want 0/00", instr4, instr8); end
    cycle(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_bypass();
    cycle(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0, 0, 1, 1);
      tests++; if (pre_act[0] !== (i == 0)) begin fails++; $display("FAIL bypass_capture4 bit%0d: got %b want %b", i, pre_act[0], (i == 0)); end
      tests++; if (pre_act[1] !== pre_exp[1]) begin fails++; $display("FAIL bypass_capture8 bit%0d: got %b want %b", i, pre_act[1], pre_exp[1]); end
    end
    cycle(0, 0, 0, 1, 0, 0, 0);
    tests++; if (instr4 !== 4'hF || bypass_select[0] !== 1'b1 || byp_dec[0] !== 1'b1) begin
      fails++; $display("FAIL bypass_decode: instr=%h sel=%b dec=%b want f/1/1", instr4, bypass_select[0], byp_dec[0]); end
    tests++; if (act_vec(1) !== exp_vec(1) || act_instr(1) != m_instr[1]) begin
      fails++; $display("FAIL bypass_dut8: got %b/%h want %b/%h", act_vec(1), instr8, exp_vec(1), m_instr[1]); end
    load(4'hF, 8'hFF);
    tests++; if (instr8 !== 8'hFF || byp_dec[1] !== 1'b1 || bypass_select[1] !== 1'b1) begin
      fails++; $display("FAIL bypass_dut8_ones: instr=%h dec=%b sel=%b want ff/1/1", instr8, byp_dec[1], bypass_select[1]); end
  endtask

  task automatic test_clamp();
    load(4'h4, 8'h54);
    tests++; if (clamp_held !== 2'b11 || hold_dec !== 2'b11) begin fails++; $display("FAIL clamp_hold: held=%b dec=%b want 11/11", clamp_held, hold_dec); end
    load(4'h0, 8'h10);
    tests++; if (clamp_held !== 2'b11 || bsr_mode !== 2'b11 || bsr_select !== 2'b11) begin
      fails++; $display("FAIL clamp_extest: held=%b mode=%b sel=%b want 11/11/11", clamp_held, bsr_mode, bsr_select); end
    load(4'h1, 8'h21);
    tests++; if (bsr_mode !== 2'b11) begin fails++; $display("FAIL clamp_sample_mode: got %b want 11", bsr_mode); end
    cycle(1, 0, 0, 0, 0, 0, 0);
    tests++; if (instr4 !== 4'h2 || instr8 !== 8'h32 || clamp_held !== 2'b11 || bsr_mode !== 2'b11) begin
      fails++; $display("FAIL clamp_tlr: instr=%h/%h held=%b mode=%b want 2/32/11/11", instr4, instr8, clamp_held, bsr_mode); end
    load(4'h5, 8'h65);
    tests++; if (clamp_held !== 2'b00 || bsr_mode !== 2'b00 || rel_dec !== 2'b11) begin
      fails++; $display("FAIL clamp_release: held=%b mode=%b dec=%b want 00/00/11", clamp_held, bsr_mode, rel_dec); end
    for (int d = 0; d < 2; d++) begin
      tests++; if (act_vec(d) !== exp_vec(d)) begin fails++; $display("FAIL clamp_decode dut%0d: got %b want %b", d, act_vec(d), exp_vec(d)); end
    end
  endtask

  task automatic test_unknown();
    load(4'h9, 8'h99);
    tests++; if (unknown_instr !== 2'b11 || bypass_select !== 2'b11 || byp_dec !== 2'b00) begin
      fails++; $display("FAIL unknown_decode: unk=%b sel=%b dec=%b want 11/11/00", unknown_instr, bypass_select, byp_dec); end
    cycle(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0, 0, 0, 0);
      tests++; if (pre_act[0] !== (i == 0 || i == 2)) begin fails++; $display("FAIL unknown_capture4 bit%0d: got %b want %b", i, pre_act[0], (i == 0 || i == 2)); end
      tests++; if (pre_act[1] !== pre_exp[1]) begin fails++; $display("FAIL unknown_capture8 bit%0d: got %b want %b", i, pre_act[1], pre_exp[1]); end
    end
  endtask

  task automatic test_ahb();
    load(4'h7, 8'h87);
    tests++; if (ahb_select !== 2'b11) begin fails++; $display("FAIL ahb_select: got %b want 11", ahb_select); end
    for (int i = 0; i < 6; i++) begin
      ahb_tdo = i[0];
      {bsr_tdo, id_tdo, bypass_tdo, tmp_tdo} = 4'($urandom);
      cycle(0, 0, 0, 0, 1, 0, 0);
      tests++; if (pre_act[0] !== ahb_tdo || pre_act[1] !== ahb_tdo) begin
        fails++; $display("FAIL ahb_tdo step%0d: got %b%b want %b", i, pre_act[1], pre_act[0], ahb_tdo); end
    end
    cycle(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      cycle(0, 0, 1, 0, 0, (i >= 4) ? ((2 >> (i - 4)) & 1) : 0, (8'h32 >> i) & 1);
    cycle(0, 1, 0, 1, 0, 0, 0);
    tests++; if (instr4 !== 4'h2 || instr8 !== 8'h32) begin fails++; $display("FAIL update_over_capture: instr=%h/%h want 2/32", instr4, instr8); end
    cycle(0, 0, 0, 1, 0, 0, 0);
    tests++; if (instr4 !== 4'h2 || instr8 !== 8'h32) begin fails++; $display("FAIL capture_ignored: instr=%h/%h want 2/32", instr4, instr8); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        int k;
        k = $urandom_range(0, 9);
        if (k < 8) load(op[0][k], op[1][k]);
        else if (k == 8) load(15, 255);
        else load($urandom_range(0, 15), $urandom_range(0, 255));
        for (int d = 0; d < 2; d++) begin
          tests++; if (act_vec(d) !== exp_vec(d) || act_instr(d) != m_instr[d]) begin
            fails++; $display("FAIL rand_load dut%0d: got %b/%h want %b/%h", d, act_vec(d), act_instr(d), exp_vec(d), m_instr[d]); end
        end
      end else begin
        for (int j = 0; j < 5; j++) begin
          {bsr_tdo, id_tdo, bypass_tdo, tmp_tdo, ahb_tdo} = 5'($urandom);
          cycle(($urandom_range(0, 19) == 0) ? 1 : 0, ($urandom_range(0, 4) == 0) ? 1 : 0,
                $urandom_range(0, 1), ($urandom_range(0, 4) == 0) ? 1 : 0,
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
          for (int d = 0; d < 2; d++) begin
            tests++; if (pre_act[d] !== pre_exp[d]) begin fails++; $display("FAIL rand_tdo dut%0d: got %b want %b", d, pre_act[d], pre_exp[d]); end
            tests++; if (act_vec(d) !== exp_vec(d) || act_instr(d) != m_instr[d]) begin
              fails++; $display("FAIL rand_state dut%0d: got %b/%h want %b/%h", d, act_vec(d), act_instr(d), exp_vec(d), m_instr[d]); end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_clamp();
    test_unknown();
    test_ahb();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
